// File: rtl/keyed_window_fsm_ctrl.sv
// Key-gated present-state register for an external combinational FSM.
// Each window of WIN_LEN cycles expects its own key; a wrong key steers the FSM to that window's decoy.
module keyed_window_fsm_ctrl #(
    parameter int                          KEY_W       = 12,
    parameter int                          NUM_KEYS    = 4,
    parameter int                          WIN_LEN     = 5,
    parameter int                          STATE_W     = 5,
    parameter logic [STATE_W-1:0]          RESET_STATE = STATE_W'(1),
    parameter logic [NUM_KEYS*KEY_W-1:0]   KEYS        = {12'h771, 12'hA64, 12'h343, 12'h2DE},
    parameter logic [NUM_KEYS*STATE_W-1:0] DECOYS      = {5'd5, 5'd2, 5'd12, 5'd15}
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   en,
    input  logic [KEY_W-1:0]                                       keyinput,
    input  logic [STATE_W-1:0]                                     nx_state,
    output logic [STATE_W-1:0]                                     pr_state,
    output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0]     win_idx,
    output logic                                                   key_ok,
    output logic                                                   unlocked,
    output logic [7:0]                                             fault_cnt
);

    localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int SLOT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_KEYS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WIN_LEN - 1);

    logic [SLOT_W-1:0]  r_slot;
    logic [IDX_W-1:0]   r_winIdx;
    logic [STATE_W-1:0] r_prState;
    logic               r_unlocked;
    logic               r_roundClean;
    logic [7:0]         r_faultCnt;

    logic [KEY_W-1:0]   w_curKey;
    logic [STATE_W-1:0] w_curDecoy;
    logic               w_keyOk;
    logic               w_slotEnd;
    logic               w_roundEnd;

    assign w_curKey   = KEYS[r_winIdx * KEY_W +: KEY_W];
    assign w_curDecoy = DECOYS[r_winIdx * STATE_W +: STATE_W];
    assign w_keyOk    = (keyinput == w_curKey);
    assign w_slotEnd  = (r_slot == LAST_SLOT);
    assign w_roundEnd = w_slotEnd && (r_winIdx == LAST_IDX);

    // Round-end takes priority over a mismatch for round_clean: the next round always starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot       <= '0;
            r_winIdx     <= '0;
            r_prState    <= RESET_STATE;
            r_unlocked   <= 1'b0;
            r_roundClean <= 1'b1;
            r_faultCnt   <= 8'd0;
        end else if (en) begin
            r_slot <= w_slotEnd ? '0 : r_slot + 1'b1;
            if (w_slotEnd) begin
                r_winIdx <= (r_winIdx == LAST_IDX) ? '0 : r_winIdx + 1'b1;
            end
            r_prState <= w_keyOk ? nx_state : w_curDecoy;
            if (!w_keyOk && (r_faultCnt != 8'hFF)) begin
                r_faultCnt <= r_faultCnt + 8'd1;
            end
            if (w_roundEnd) begin
                r_unlocked   <= r_roundClean & w_keyOk;
                r_roundClean <= 1'b1;
            end else if (!w_keyOk) begin
                r_unlocked   <= 1'b0;
                r_roundClean <= 1'b0;
            end
        end
    end

    assign pr_state  = r_prState;
    assign win_idx   = r_winIdx;
    assign key_ok    = w_keyOk;
    assign unlocked  = r_unlocked;
    assign fault_cnt = r_faultCnt;

endmodule
